// File: rtl/tlc_pkg.sv
// Shared light and state encodings for the highway/country-road phase scheduler.
package tlc_pkg;

  localparam int unsigned LIGHT_W = 2;
  localparam int unsigned STATE_W = 3;

  localparam logic [LIGHT_W-1:0] RED = 2'b00;
  localparam logic [LIGHT_W-1:0] YEL = 2'b01;
  localparam logic [LIGHT_W-1:0] GRN = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    HG   = 3'd0,
    HY   = 3'd1,
    AR1  = 3'd2,
    WALK = 3'd3,
    CG   = 3'd4,
    CY   = 3'd5,
    AR2  = 3'd6
  } state_e;

  // Highway lamp for a given phase; every non-highway phase shows red.
  function automatic logic [LIGHT_W-1:0] hwy_light(input state_e s);
    case (s)
      HG:      hwy_light = GRN;
      HY:      hwy_light = YEL;
      default: hwy_light = RED;
    endcase
  endfunction

  function automatic logic [LIGHT_W-1:0] ctrd_light(input state_e s);
    case (s)
      CG:      ctrd_light = GRN;
      CY:      ctrd_light = YEL;
      default: ctrd_light = RED;
    endcase
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: counts tick pulses, restarts on phase change, saturates at all-ones.
module tlc_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             restart_i,
  input  logic             tick_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tlc_phase_sched.sv
// Timed phase scheduler: FSM, pedestrian request latch and registered lamp decode.
module tlc_phase_sched
  import tlc_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned T_HWY_MIN  = 20,
  parameter int unsigned T_CTRD_MAX = 15,
  parameter int unsigned T_YEL      = 4,
  parameter int unsigned T_ALLRED   = 2,
  parameter int unsigned T_WALK     = 10
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               tick,
  input  logic               x,
  input  logic               ped_req,
  output logic [LIGHT_W-1:0] hwy,
  output logic [LIGHT_W-1:0] ctrd,
  output logic               walk,
  output logic               ped_ack,
  output logic [STATE_W-1:0] state_o
);

  // Last timer value of each interval; exit happens on a tick at this value.
  localparam logic [CNT_W-1:0] HWY_LAST  = CNT_W'(T_HWY_MIN - 1);
  localparam logic [CNT_W-1:0] CTRD_LAST = CNT_W'(T_CTRD_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(T_WALK - 1);

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [LIGHT_W-1:0] hwy_q, ctrd_q;
  logic               walk_q, ack_q;
  logic [CNT_W-1:0]   timer;
  logic               restart;
  logic               enter_walk;

  tlc_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .clr      (clr),
    .restart_i(restart),
    .tick_i   (tick),
    .cnt_o    (timer)
  );

  // Next phase; an illegal encoding falls back to highway green regardless of tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HG:   if (tick && (timer >= HWY_LAST) && (x || pend_q)) state_d = HY;
      HY:   if (tick && (timer == YEL_LAST)) state_d = AR1;
      AR1:  if (tick && (timer == AR_LAST)) state_d = pend_q ? WALK : CG;
      WALK: if (tick && (timer == WALK_LAST)) state_d = x ? CG : AR2;
      CG:   if (tick && (!x || (timer == CTRD_LAST))) state_d = CY;
      CY:   if (tick && (timer == YEL_LAST)) state_d = AR2;
      AR2:  if (tick && (timer == AR_LAST)) state_d = HG;
      default: state_d = HG;
    endcase
  end

  assign restart    = (state_d != state_q);
  assign enter_walk = (state_d == WALK) && (state_q != WALK);

  // Entering WALK serves the request and beats a same-cycle button press.
  always_comb begin
    pend_d = pend_q;
    if (enter_walk) begin
      pend_d = 1'b0;
    end else if (ped_req && (state_q != WALK)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= HG;
      pend_q  <= 1'b0;
      hwy_q   <= GRN;
      ctrd_q  <= RED;
      walk_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      hwy_q   <= hwy_light(state_d);
      ctrd_q  <= ctrd_light(state_d);
      walk_q  <= (state_d == WALK);
      ack_q   <= enter_walk;
    end
  end

  assign hwy     = hwy_q;
  assign ctrd    = ctrd_q;
  assign walk    = walk_q;
  assign ped_ack = ack_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_tlc_phase_sched.sv
// Directed scenarios for tlc_phase_sched with a queued expectation scoreboard.
module tb_tlc_phase_sched;
  import tlc_pkg::*;

  logic       clk = 1'b0;
  logic       clr, tick, x, ped_req;
  logic [1:0] hwy, ctrd;
  logic       walk, ped_ack;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  tlc_phase_sched #(
    .CNT_W(8), .T_HWY_MIN(4), .T_CTRD_MAX(3), .T_YEL(2), .T_ALLRED(1), .T_WALK(2)
  ) dut (
    .clk(clk), .clr(clr), .tick(tick), .x(x), .ped_req(ped_req),
    .hwy(hwy), .ctrd(ctrd), .walk(walk), .ped_ack(ped_ack), .state_o(state_o)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] hwy;
    logic [1:0] ctrd;
    logic       walk;
    logic       ack;
  } obs_t;

  obs_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  int    per   = 1;
  int    ped_a = -1;
  int    ped_b = -1;
  logic  x_v   = 1'b0;
  string scen  = "init";

  // Expected lamps written out from the light table: RED=00, YEL=01, GRN=10.
  function automatic obs_t mk(input state_e st, input logic ack);
    obs_t o;
    o.st   = st;
    o.ack  = ack;
    o.walk = (st == WALK);
    case (st)
      HG:      begin o.hwy = 2'b10; o.ctrd = 2'b00; end
      HY:      begin o.hwy = 2'b01; o.ctrd = 2'b00; end
      CG:      begin o.hwy = 2'b00; o.ctrd = 2'b10; end
      CY:      begin o.hwy = 2'b00; o.ctrd = 2'b01; end
      default: begin o.hwy = 2'b00; o.ctrd = 2'b00; end
    endcase
    return o;
  endfunction

  // One clock: drive inputs for this cycle, expect st (and ack) after the edge.
  task automatic step(input logic c, input state_e st, input logic ack);
    clr     = c;
    tick    = c ? 1'b1 : ((cyc % per) == (per - 1));
    x       = x_v;
    ped_req = !c && ((cyc == ped_a) || (cyc == ped_b));
    @(posedge clk);
    #1;
    exp_q.push_back(mk(st, ack));
    cyc = c ? 0 : cyc + 1;
  endtask

  // n cycles in phase st, starting with the step that enters it.
  task automatic run(input state_e st, input int n);
    for (int i = 0; i < n; i++) step(1'b0, st, (st == WALK) && (i == 0));
  endtask

  task automatic do_reset(input int n);
    x_v = 1'b0; ped_a = -1; ped_b = -1; per = 1;
    for (int i = 0; i < n; i++) step(1'b1, HG, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = '{st: state_o, hwy: hwy, ctrd: ctrd, walk: walk, ack: ped_ack};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s t=%0t: got st=%0d hwy=%b ctrd=%b walk=%b ack=%b, want st=%0d hwy=%b ctrd=%b walk=%b ack=%b",
                 scen, $time, a.st, a.hwy, a.ctrd, a.walk, a.ack, e.st, e.hwy, e.ctrd, e.walk, e.ack);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    clr = 1'b1; tick = 1'b0; x = 1'b0; ped_req = 1'b0;

    scen = "idle_hg";
    do_reset(2);
    run(HG, 50);

    scen = "x_maxgreen";
    do_reset(2);
    x_v = 1'b1;
    run(HG, 3); run(HY, 2); run(AR1, 1); run(CG, 3); run(CY, 2); run(AR2, 1);
    run(HG, 4); run(HY, 1);

    scen = "x_drop";
    do_reset(2);
    x_v = 1'b1;
    run(HG, 3); run(HY, 2); run(AR1, 1); run(CG, 2);
    x_v = 1'b0;
    run(CY, 2); run(AR2, 1); run(HG, 6);

    scen = "ped_walk";
    do_reset(2);
    ped_a = 1; ped_b = 8;
    run(HG, 3); run(HY, 2); run(AR1, 1); run(WALK, 2); run(AR2, 1); run(HG, 8);

    scen = "tick_div4";
    do_reset(2);
    per = 4; x_v = 1'b1;
    run(HG, 15); run(HY, 8); run(AR1, 4); run(CG, 12); run(CY, 8); run(AR2, 4);
    run(HG, 8);

    scen = "clr_in_cg";
    do_reset(2);
    x_v = 1'b1; ped_a = 7;
    run(HG, 3); run(HY, 2); run(AR1, 1); run(CG, 2);
    step(1'b1, HG, 1'b0);
    x_v = 1'b0; ped_a = -1;
    run(HG, 10);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
